// File: rtl/chunked_adder_pkg.sv
// Shared types and helpers for the chunk-serial adder/subtractor.
package chunked_adder_pkg;

    // Operation sequencing: accept operands, add one chunk per cycle, hold result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the chunk index counter; a single-chunk configuration still needs one bit.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunked_adder_seq_chunk.sv
// CHUNK-bit combinational ripple-carry slice; also exposes the carry into its top bit
// so the caller can derive two's-complement overflow on the final chunk.
module adder_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    // Ripple the carry through CHUNK full adders, LSB first.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed CHUNK bits per clock
// through a single ripple slice and a carry register, with valid/ready on both sides.
module chunked_adder_seq
    import chunked_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IW     = idx_width(NCHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunked_adder_seq: WIDTH must be a multiple of CHUNK");
    end

    state_t           state, state_nxt;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_r, b_r;
    logic             carry;
    logic [WIDTH-1:0] s_r;
    logic             cout_r, ovf_r;

    logic [31:0]      shamt;
    logic [CHUNK-1:0] a_ch, b_ch, sl_s;
    logic             sl_co, sl_cmsb;
    logic [WIDTH-1:0] lane_mask, s_merge;
    logic             last;
    logic             accept;

    // Select the active operand chunk and merge the slice sum into its result lane.
    // Shifts stand in for idx*CHUNK part-selects so any NCHUNK (including 1) works.
    always_comb begin
        shamt     = 32'(idx) * CHUNK;
        a_ch      = CHUNK'(a_r >> shamt);
        b_ch      = CHUNK'(b_r >> shamt);
        lane_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
        s_merge   = (s_r & ~lane_mask) | (WIDTH'(sl_s) << shamt);
        last      = (idx == IW'(NCHUNK - 1));
    end

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a     (a_ch),
        .b     (b_ch),
        .cin   (carry),
        .s     (sl_s),
        .cout  (sl_co),
        .c_msb (sl_cmsb)
    );

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state and handshake outputs; in_valid is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Operand capture on accept, then one chunk per RUN cycle; flags taken from the last chunk.
    // Subtraction is A + ~B + 1, so B is inverted at capture and the carry seeded with 1.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_r    <= '0;
            b_r    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            a_r   <= A;
            b_r   <= B ^ {WIDTH{sub}};
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
        end else if (state == ST_RUN) begin
            s_r   <= s_merge;
            carry <= sl_co;
            idx   <= idx + IW'(1);
            if (last) begin
                cout_r <= sl_co;
                ovf_r  <= sl_cmsb ^ sl_co;
            end
        end
    end

    assign S    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule
